// File: rtl/emmc_cmd_tx_pkg.sv
// Shared definitions for the eMMC command transmitter: FSM state encoding and frame geometry.
package emmc_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_CRC  = 3'd2;
  localparam logic [2:0] ST_END  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    DATA = ST_DATA,
    CRC  = ST_CRC,
    END  = ST_END,
    GAP  = ST_GAP
  } state_e;

  localparam int CMD_FRAME_BITS = 48;
  localparam int CMD_HDR_BITS   = 40;
  localparam int CRC7_BITS      = 7;
  localparam int CMD_IDX_W      = 6;
  localparam int CMD_ARG_W      = 32;

  // Start bit 0 followed by transmission bit 1 (host to device).
  localparam logic [1:0] CMD_PREFIX = 2'b01;

endpackage

// File: rtl/emmc_cmd_tx_if.sv
// Command request channel between the host scheduler (master) and emmc_cmd_tx (slave).
interface emmc_cmd_tx_if;
  import emmc_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CMD_IDX_W-1:0] cmd_index;
  logic [CMD_ARG_W-1:0] cmd_arg;
  logic                 crc_err_inj;

  modport master (
    output cmd_valid, cmd_index, cmd_arg, crc_err_inj,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, crc_err_inj,
    output cmd_ready
  );
endinterface

// File: rtl/emmc_cmd_tx_crc7.sv
// Serial CRC-7 (x^7 + x^3 + 1, zero seed), one data bit per enabled clock, MSB first.
module crc7 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       data_in,
  output logic [6:0] crc7
);
  logic [6:0] crc_q;
  logic       fb;

  assign fb   = data_in ^ crc_q[6];
  assign crc7 = crc_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      crc_q <= '0;
    end else if (enable) begin
      crc_q <= {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    end
  end
endmodule

// File: rtl/emmc_cmd_tx.sv
// eMMC CMD-line frame sequencer: start/tx/index/arg, CRC-7, end bit, then an NCC idle gap.
// Optional build macro EMMC_CMD_CRC_ERR_INJ_EN enables per-frame inversion of crc[0].
module emmc_cmd_tx
  import emmc_pkg::*;
#(
  parameter int CLKDIV = 4,
  parameter int NCC    = 8
) (
  input  logic           clk,
  input  logic           rstn,
  emmc_cmd_tx_if.slave   cmd_if,
  output logic           cmd_out,
  output logic           cmd_oe,
  output logic           busy,
  output logic           done
);
  localparam int DIV_W   = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam int CNT_MAX = (NCC > CMD_HDR_BITS) ? NCC : CMD_HDR_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] DIV_DONE = DIV_W'(CLKDIV - 2);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(CMD_HDR_BITS - 1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC7_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(NCC - 1);

  state_e                  state_q;
  logic [DIV_W-1:0]        div_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [CMD_HDR_BITS-1:0] sreg_q;
  logic                    cmd_out_q;
  logic                    cmd_oe_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    strobe;
  logic                    crc_clr;
  logic                    crc_rstn;
  logic                    crc_en;
  logic [CRC7_BITS-1:0]    crc7_w;
  logic [CRC7_BITS-1:0]    crc_tx;

  assign strobe   = (div_q == DIV_LAST);
  assign crc_clr  = (state_q == IDLE) && cmd_if.cmd_valid;
  assign crc_rstn = rstn & ~crc_clr;
  assign crc_en   = (state_q == DATA) && strobe;

`ifdef EMMC_CMD_CRC_ERR_INJ_EN
  logic inj_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inj_q <= 1'b0;
    end else if (crc_clr) begin
      inj_q <= cmd_if.crc_err_inj;
    end
  end

  assign crc_tx = crc7_w ^ {{(CRC7_BITS-1){1'b0}}, inj_q};
`else
  logic unused_crc_err_inj;

  assign unused_crc_err_inj = cmd_if.crc_err_inj;
  assign crc_tx             = crc7_w;
`endif

  crc7 u_crc7 (
    .clk     (clk),
    .rstn    (crc_rstn),
    .enable  (crc_en),
    .data_in (sreg_q[CMD_HDR_BITS-1]),
    .crc7    (crc7_w)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        div_q <= strobe ? '0 : div_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (cmd_if.cmd_valid) begin
            state_q   <= DATA;
            sreg_q    <= {CMD_PREFIX, cmd_if.cmd_index, cmd_if.cmd_arg};
            div_q     <= '0;
            bit_cnt_q <= '0;
            cmd_out_q <= CMD_PREFIX[1];
            cmd_oe_q  <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        DATA: begin
          if (strobe) begin
            sreg_q <= {sreg_q[CMD_HDR_BITS-2:0], 1'b0};
            if (bit_cnt_q == HDR_LAST) begin
              // The generator absorbs the last header bit on this same edge; the
              // MSB of its next value is simply the current crc[5].
              state_q   <= CRC;
              bit_cnt_q <= '0;
              cmd_out_q <= crc7_w[CRC7_BITS-2];
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              cmd_out_q <= sreg_q[CMD_HDR_BITS-2];
            end
          end
        end
        CRC: begin
          if (strobe) begin
            if (bit_cnt_q == CRC_LAST) begin
              state_q   <= END;
              bit_cnt_q <= '0;
              cmd_out_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              cmd_out_q <= crc_tx[3'(3'd5 - bit_cnt_q[2:0])];
            end
          end
        end
        END: begin
          done_q <= (div_q == DIV_DONE);
          if (strobe) begin
            state_q   <= GAP;
            bit_cnt_q <= '0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
          end
        end
        GAP: begin
          if (strobe) begin
            if (bit_cnt_q == GAP_LAST) begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_ready = ready_q;
  assign cmd_out          = cmd_out_q;
  assign cmd_oe           = cmd_oe_q;
  assign busy             = busy_q;
  assign done             = done_q;
endmodule

// File: tb/tb_emmc_cmd_tx.sv
// Bench for emmc_cmd_tx: cycle-level frame model plus directed literal frames and random traffic.
module tb_emmc_cmd_tx;
  localparam int C         = 4;
  localparam int NCC       = 8;
  localparam int FRAME_CYC = 48 * C;
  localparam int TOTAL     = (48 + NCC) * C;

  logic clk = 1'b0;
  logic rstn;
  logic cmd_out, cmd_oe, busy, done;

  emmc_cmd_tx_if bus ();

  emmc_cmd_tx #(.CLKDIV(C), .NCC(NCC)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .cmd_if  (bus.slave),
    .cmd_out (cmd_out),
    .cmd_oe  (cmd_oe),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [6:0] r;
    logic       fb;
    r = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ r[6];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg,
                                            input logic inj);
    logic [39:0] hdr;
    logic [47:0] f;
    hdr = {2'b01, idx, arg};
    f   = {hdr, crc7_ref(hdr), 1'b1};
`ifdef EMMC_CMD_CRC_ERR_INJ_EN
    if (inj) f[1] = ~f[1];
`else
    if (inj) f = f;
`endif
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: cycles elapsed since the accepting edge; idle when inactive.
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [47:0] m_frame  = '0;
  bit          chk_en   = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!m_active) begin
      if (bus.cmd_valid === 1'b1) begin
        m_active = 1'b1;
        m_t      = 1;
        m_frame  = frame_ref(bus.cmd_index, bus.cmd_arg, bus.crc_err_inj);
      end
    end else begin
      m_t++;
      if (m_t > TOTAL) m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = 5'b10100;
      if (m_active) begin
        if (m_t <= FRAME_CYC)
          exp_v = {m_frame[47 - (m_t - 1) / C], 1'b1, 1'b0, 1'b1, (m_t == FRAME_CYC)};
        else
          exp_v = 5'b10010;
      end
      act_v = {cmd_out, cmd_oe, bus.cmd_ready, busy, done};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_cmp t=%0d out_oe_rdy_busy_done actual=%b required=%b",
                 m_t, act_v, exp_v);
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (m_active) begin
      @(negedge clk);
      guard++;
      if (guard > 2 * TOTAL) begin
        chk("wait_idle_timeout", 64'(guard), 64'(0));
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input logic inj,
                           input bit hold, input bit toggle,
                           output logic [47:0] cap, output int oe_cnt,
                           output int done_at, output int ready_at);
    wait_idle();
    bus.cmd_valid   = 1'b1;
    bus.cmd_index   = idx;
    bus.cmd_arg     = arg;
    bus.crc_err_inj = inj;
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
    cap = '0; oe_cnt = 0; done_at = -1; ready_at = -1;
    for (int c = 1; c <= TOTAL + 1; c++) begin
      @(negedge clk);
      if (cmd_oe === 1'b1) oe_cnt++;
      if (c <= FRAME_CYC && (c - 1) % C == 0) cap = {cap[46:0], cmd_out};
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (bus.cmd_ready === 1'b1 && ready_at < 0) ready_at = c;
      if (toggle) begin
        if (c < FRAME_CYC) begin
          bus.cmd_valid = 1'($urandom_range(0, 1));
          bus.cmd_index = 6'($urandom);
          bus.cmd_arg   = $urandom;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] cap;
    int oe_cnt, done_at, ready_at;

    rstn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0; bus.crc_err_inj = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({cmd_out, cmd_oe, bus.cmd_ready, busy, done}), 64'(5'b10100));
    rstn = 1'b1;

    // Pin the reference model to published frames.
    chk("model_crc_cmd0", 64'(crc7_ref(40'h4000000000)), 64'(7'h4A));
    chk("model_crc_cmd8", 64'(crc7_ref(40'h48000001AA)), 64'(7'h43));
    chk("model_frame_cmd17", 64'(frame_ref(6'd17, 32'h0, 1'b0)), 64'(48'h510000000055));

    run_frame(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, cap, oe_cnt, done_at, ready_at);
    chk("cmd0_frame", 64'(cap), 64'(48'h400000000095));
    chk("cmd0_done_at", 64'(done_at), 64'(192));
    chk("cmd0_oe_cycles", 64'(oe_cnt), 64'(192));
    chk("cmd0_ready_at", 64'(ready_at), 64'(225));

    run_frame(6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b1, cap, oe_cnt, done_at, ready_at);
    chk("cmd8_frame_toggled_valid", 64'(cap), 64'(48'h48000001AA87));
    chk("cmd8_oe_cycles", 64'(oe_cnt), 64'(192));

    run_frame(6'd17, 32'h0, 1'b0, 1'b1, 1'b0, cap, oe_cnt, done_at, ready_at);
    chk("cmd17_first_frame", 64'(cap), 64'(48'h510000000055));
    chk("cmd17_ready_at", 64'(ready_at), 64'(225));
    run_frame(6'd17, 32'h0, 1'b0, 1'b0, 1'b0, cap, oe_cnt, done_at, ready_at);
    chk("cmd17_back_to_back_frame", 64'(cap), 64'(48'h510000000055));
    chk("cmd17_b2b_done_at", 64'(done_at), 64'(192));

`ifdef EMMC_CMD_CRC_ERR_INJ_EN
    run_frame(6'd0, 32'h0, 1'b1, 1'b0, 1'b0, cap, oe_cnt, done_at, ready_at);
    chk("inj_cmd0_frame", 64'(cap), 64'(48'h400000000097));
`else
    run_frame(6'd0, 32'h0, 1'b1, 1'b0, 1'b0, cap, oe_cnt, done_at, ready_at);
    chk("inj_ignored_cmd0_frame", 64'(cap), 64'(48'h400000000095));
`endif
    run_frame(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, cap, oe_cnt, done_at, ready_at);
    chk("after_inj_cmd0_frame", 64'(cap), 64'(48'h400000000095));

    // Abort mid-frame at bit 20, then confirm the CRC restarts from zero.
    wait_idle();
    bus.cmd_valid = 1'b1; bus.cmd_index = 6'd8; bus.cmd_arg = 32'h000001AA;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 20 * C + 1; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_at = c;
    end
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({cmd_out, cmd_oe, bus.cmd_ready, busy, done}), 64'(5'b10100));
    chk("abort_no_done", 64'(done_at), 64'(-1));
    rstn = 1'b1;
    run_frame(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, cap, oe_cnt, done_at, ready_at);
    chk("post_abort_cmd0_frame", 64'(cap), 64'(48'h400000000095));

    // Random traffic with occasional resets, checked cycle by cycle by the model.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      bus.cmd_valid   = ($urandom_range(0, 7) == 0);
      bus.cmd_index   = 6'($urandom);
      bus.cmd_arg     = $urandom;
      bus.crc_err_inj = 1'($urandom_range(0, 1));
      rstn            = ($urandom_range(0, 1499) != 0);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rstn = 1'b1;
    repeat (TOTAL + 5) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
